simmem_release_bank: RTL

- Output-side partner of the per-entry delay countdown bank in the simulated memory controller.
- Stores one response payload per bank entry and receives the per-entry release_en vector from the delay bank.
- Selects one releasable entry at a time, round-robin, and presents it on a registered valid/ready output.
- Reports the released entry back to the delay bank as a one-hot address so the delay bank clears that entry's release_en.

---
 rtl/simmem_release_bank.sv | 75 +++++++
 1 files changed

// File: rtl/simmem_release_bank.sv
// simmem_release_bank: holds one response per entry and releases releasable entries round-robin over a registered valid/ready port (define SIMMEM_RELEASE_FIXED_PRIO_EN for lowest-index-first selection)
module simmem_release_bank #(
  parameter int Capacity = 16,
  parameter int PayloadWidth = 8,
  localparam int IdxWidth = $clog2(Capacity)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    in_valid_i,
  input  logic [IdxWidth-1:0]     in_identifier_i,
  input  logic [PayloadWidth-1:0] in_payload_i,
  input  logic [Capacity-1:0]     release_en_i,
  output logic [Capacity-1:0]     address_released_onehot_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [PayloadWidth-1:0] out_payload_o,
  output logic [IdxWidth-1:0]     out_identifier_o,
  output logic                    error_o
);
  logic [Capacity-1:0] entry_valid_q, inflight, eligible, released, cleared, store_oh;
  logic [PayloadWidth-1:0] payload_q [Capacity];
  logic [PayloadWidth-1:0] out_payload_q;
  logic [IdxWidth-1:0] out_id_q, sel, start;
  logic out_valid_q, error_q, hs, load, conflict, store_ok;
  assign hs = out_valid_q & out_ready_i;
  assign inflight = out_valid_q ? Capacity'(1) << out_id_q : '0;
  assign released = hs ? inflight : '0;
  assign eligible = release_en_i & entry_valid_q & ~inflight;
  assign load = |eligible & (~out_valid_q | out_ready_i);
  assign cleared = entry_valid_q & ~released;
  assign store_oh = in_valid_i ? Capacity'(1) << in_identifier_i : '0;
  assign conflict = |(store_oh & cleared);
  assign store_ok = |store_oh & ~conflict;
`ifdef SIMMEM_RELEASE_FIXED_PRIO_EN
  assign start = '0;
`else
  logic [IdxWidth-1:0] rr_ptr_q;
  assign start = rr_ptr_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) rr_ptr_q <= '0;
    else if (load) rr_ptr_q <= IdxWidth'((int'(sel) + 1) % Capacity);
`endif
  always_comb begin
    sel = '0;
    for (int i = Capacity - 1; i >= 0; i--) begin
      logic [IdxWidth-1:0] k;
      k = IdxWidth'((int'(start) + i) % Capacity);
      sel = eligible[k] ? k : sel;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      entry_valid_q <= '0;
      out_valid_q   <= 1'b0;
      out_id_q      <= '0;
      out_payload_q <= '0;
      error_q       <= 1'b0;
    end else begin
      entry_valid_q <= cleared | (store_ok ? store_oh : '0);
      out_valid_q   <= load | (out_valid_q & ~out_ready_i);
      error_q       <= error_q | conflict;
      if (load) begin
        out_id_q      <= sel;
        out_payload_q <= payload_q[sel];
      end
    end
  always_ff @(posedge clk_i)
    for (int k = 0; k < Capacity; k++)
      if (store_ok && store_oh[k]) payload_q[k] <= in_payload_i;
  assign address_released_onehot_o = released;
  assign out_valid_o = out_valid_q;
  assign out_payload_o = out_payload_q;
  assign out_identifier_o = out_id_q;
  assign error_o = error_q;
endmodule
